// File: rtl/pr_bus_pkg.sv
// Shared types for the processor bus arbiter: FSM states, bus owner and the
// latched transfer descriptor.
package pr_bus_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CPU_BUS = 2'd1,
      DMA_BUS = 2'd2,
      DONE    = 2'd3
   } state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_t;

   typedef struct packed {
      logic        we;
      logic [31:2] addr;
      logic [31:0] wd;
      logic [3:0]  be;
   } pr_xfer_t;

endpackage

// File: rtl/pr_bus_timeout.sv
// Bus wait-state watchdog: counts cycles spent with the strobe raised and flags
// the cycle in which the limit is reached. Only built with PR_BUS_TIMEOUT_EN.
module pr_bus_timeout #(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_run,
   output logic o_expire
);

   localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic [CW-1:0] r_cnt;

   // r_cnt holds the number of strobe cycles already elapsed before this one
   assign o_expire = i_run && (r_cnt == CW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_run && !o_expire) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pr_bus_arbiter.sv
// Two-master (CPU priority, DMA with starvation guard) req/ack processor bus arbiter.
// Define PR_BUS_TIMEOUT_EN to add the ack watchdog and bus_err reporting.
module pr_bus_arbiter
   import pr_bus_pkg::*;
#(
   parameter int          STARVE_MAX  = 4,
`ifdef PR_BUS_TIMEOUT_EN
   parameter int          TIMEOUT_CYC = 64,
`endif
   parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [29:0] cpu_addr,
   input  logic [31:0] cpu_wd,
   input  logic [3:0]  cpu_be,
   output logic [31:0] cpu_rd,
   output logic        cpu_done,
   output logic        cpu_stall,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [29:0] dma_addr,
   input  logic [31:0] dma_wd,
   input  logic [3:0]  dma_be,
   output logic [31:0] dma_rd,
   output logic        dma_done,
   output logic        bus_req,
   input  logic        bus_ack,
   output logic [29:0] PrAddr,
   output logic [31:0] PrWD,
   output logic [3:0]  PrBE,
   output logic        IOWrite,
   input  logic [31:0] PrRD,
   output logic        bus_err
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   state_t        r_state;
   owner_t        r_owner;
   pr_xfer_t      r_xfer;
   logic [31:0]   r_cpu_rd;
   logic [31:0]   r_dma_rd;
   logic [SW-1:0] r_starve;

   pr_xfer_t      w_cpu_x;
   pr_xfer_t      w_dma_x;
   pr_xfer_t      w_win_x;
   logic          w_starved;
   logic          w_dma_win;
   logic          w_grant;
   logic          w_bus;
   logic          w_timeout;
   logic          w_finish;
   logic [31:0]   w_rd_next;

   assign w_cpu_x   = '{cpu_we, cpu_addr, cpu_wd, cpu_be};
   assign w_dma_x   = '{dma_we, dma_addr, dma_wd, dma_be};
   assign w_starved = (r_starve == SW'(STARVE_MAX));
   assign w_dma_win = dma_req && (!cpu_req || w_starved);
   assign w_win_x   = w_dma_win ? w_dma_x : w_cpu_x;
   assign w_grant   = (r_state == IDLE) && (cpu_req || dma_req);
   assign w_bus     = (r_state == CPU_BUS) || (r_state == DMA_BUS);
   assign w_finish  = w_bus && (bus_ack || w_timeout);
   // A real ack always beats an expiry landing in the same cycle
   assign w_rd_next = (w_timeout && !bus_ack) ? ERR_DATA : PrRD;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_owner  <= OWN_CPU;
         r_xfer   <= '0;
         r_cpu_rd <= '0;
         r_dma_rd <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant) begin
                  r_state <= w_dma_win ? DMA_BUS : CPU_BUS;
                  r_owner <= w_dma_win ? OWN_DMA : OWN_CPU;
                  r_xfer  <= w_win_x;
               end
            end
            CPU_BUS, DMA_BUS: begin
               if (w_finish) begin
                  r_state <= DONE;
                  if (r_owner == OWN_DMA) r_dma_rd <= w_rd_next;
                  else                    r_cpu_rd <= w_rd_next;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Withdrawing the DMA request forfeits any accumulated priority
   always_ff @(posedge clk) begin
      if (rst || !dma_req) begin
         r_starve <= '0;
      end else if (w_grant) begin
         if (w_dma_win)       r_starve <= '0;
         else if (!w_starved) r_starve <= r_starve + 1'b1;
      end
   end

`ifdef PR_BUS_TIMEOUT_EN
   logic r_err;

   pr_bus_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_grant),
      .i_run    (w_bus),
      .o_expire (w_timeout)
   );

   always_ff @(posedge clk) begin
      if (rst) r_err <= 1'b0;
      else     r_err <= w_timeout && !bus_ack;
   end

   assign bus_err = r_err;
`else
   assign w_timeout = 1'b0;
   assign bus_err   = 1'b0;
`endif

   assign bus_req   = w_bus;
   assign IOWrite   = r_xfer.we & w_bus;
   assign PrAddr    = r_xfer.addr;
   assign PrWD      = r_xfer.wd;
   assign PrBE      = r_xfer.be;
   assign cpu_done  = (r_state == DONE) && (r_owner == OWN_CPU);
   assign dma_done  = (r_state == DONE) && (r_owner == OWN_DMA);
   assign cpu_rd    = r_cpu_rd;
   assign dma_rd    = r_dma_rd;
   assign cpu_stall = cpu_req & ~cpu_done & ~rst;

endmodule

// File: tb/tb_pr_bus_arbiter.sv
// Scoreboard bench for pr_bus_arbiter: transaction-level arbitration model feeds an
// expected queue, a bus-device model answers strobes, a monitor checks every cycle.
module tb_pr_bus_arbiter;

   localparam int          STARVE_MAX = 4;
   localparam logic [31:0] ERR_DATA   = 32'hDEAD_BEEF;
`ifdef PR_BUS_TIMEOUT_EN
   localparam int          TIMEOUT_CYC = 8;
   localparam int          TO_LAT      = TIMEOUT_CYC + 1;
`else
   localparam int          TO_LAT      = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [29:0] cpu_addr = '0;
   logic [31:0] cpu_wd = '0;
   logic [3:0]  cpu_be = '0;
   logic [31:0] cpu_rd;
   logic        cpu_done, cpu_stall;
   logic        dma_req = 1'b0, dma_we = 1'b0;
   logic [29:0] dma_addr = '0;
   logic [31:0] dma_wd = '0;
   logic [3:0]  dma_be = '0;
   logic [31:0] dma_rd;
   logic        dma_done;
   logic        bus_req, IOWrite, bus_err;
   logic        bus_ack = 1'b0;
   logic [29:0] PrAddr;
   logic [31:0] PrWD;
   logic [3:0]  PrBE;
   logic [31:0] PrRD = '0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          own_dma;
      bit          we;
      logic [29:0] addr;
      logic [31:0] wd;
      logic [3:0]  be;
      logic [31:0] rd;
      bit          err;
   } exp_t;

   exp_t exp_q[$];

   int          dev_wait  = 0;
   logic [31:0] dev_rd    = '0;
   bit          dev_never = 1'b0;
   bit          stray_ack = 1'b0;

   bit cpu_pend = 1'b0;
   bit dma_pend = 1'b0;
   int m_starve = 0;

   pr_bus_arbiter #(
      .STARVE_MAX  (STARVE_MAX),
`ifdef PR_BUS_TIMEOUT_EN
      .TIMEOUT_CYC (TIMEOUT_CYC),
`endif
      .ERR_DATA    (ERR_DATA)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wd    (cpu_wd),
      .cpu_be    (cpu_be),
      .cpu_rd    (cpu_rd),
      .cpu_done  (cpu_done),
      .cpu_stall (cpu_stall),
      .dma_req   (dma_req),
      .dma_we    (dma_we),
      .dma_addr  (dma_addr),
      .dma_wd    (dma_wd),
      .dma_be    (dma_be),
      .dma_rd    (dma_rd),
      .dma_done  (dma_done),
      .bus_req   (bus_req),
      .bus_ack   (bus_ack),
      .PrAddr    (PrAddr),
      .PrWD      (PrWD),
      .PrBE      (PrBE),
      .IOWrite   (IOWrite),
      .PrRD      (PrRD),
      .bus_err   (bus_err)
   );

   always #5 clk = ~clk;

   task automatic finish_sim();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic set_cpu(input bit we, input logic [29:0] a, input logic [31:0] wd, input logic [3:0] be);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wd = wd; cpu_be = be;
      cpu_pend = 1'b1;
   endtask

   task automatic set_dma(input bit we, input logic [29:0] a, input logic [31:0] wd, input logic [3:0] be);
      dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wd = wd; dma_be = be;
      dma_pend = 1'b1;
   endtask

   task automatic rand_cpu();
      set_cpu(1'($urandom), 30'($urandom), $urandom, 4'($urandom));
   endtask

   task automatic rand_dma();
      set_dma(1'($urandom), 30'($urandom), $urandom, 4'($urandom));
   endtask

   // Decide the next grant from the pending requests, queue the expected completion,
   // then wait (bounded) for the winner's done and withdraw its request.
   task automatic serve(input int wait_c, input bit never, input logic [31:0] rdv,
                        input bit from_done, output bit won_dma);
      exp_t e;
      int   lat;
      bit   seen;
      won_dma = dma_pend && (!cpu_pend || m_starve == STARVE_MAX);
      if (won_dma)       m_starve = 0;
      else if (dma_pend) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
      else               m_starve = 0;
      e.own_dma = won_dma;
      e.we      = won_dma ? dma_we   : cpu_we;
      e.addr    = won_dma ? dma_addr : cpu_addr;
      e.wd      = won_dma ? dma_wd   : cpu_wd;
      e.be      = won_dma ? dma_be   : cpu_be;
      e.rd      = never ? ERR_DATA : rdv;
      e.err     = never;
      dev_wait  = wait_c;
      dev_rd    = rdv;
      dev_never = never;
      exp_q.push_back(e);
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 300) begin
         step();
         lat++;
         seen = won_dma ? dma_done : cpu_done;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: no %s done within %0d cycles", won_dma ? "dma" : "cpu", lat);
         finish_sim();
      end
      check("latency", lat, (never ? TO_LAT : wait_c + 2) + (from_done ? 1 : 0));
      if (won_dma) begin dma_req = 1'b0; dma_pend = 1'b0; end
      else         begin cpu_req = 1'b0; cpu_pend = 1'b0; end
      dev_never = 1'b0;
   endtask

   // Bus device: acks after dev_wait strobe cycles; stray_ack drives ack with no strobe
   initial begin
      int cnt = 0;
      forever begin
         @(negedge clk);
         #2;
         if (bus_req) begin
            if (!dev_never && cnt == dev_wait) begin
               bus_ack = 1'b1;
               PrRD    = dev_rd;
            end else begin
               bus_ack = 1'b0;
               PrRD    = $urandom;
            end
            cnt++;
         end else begin
            cnt     = 0;
            bus_ack = stray_ack;
            PrRD    = $urandom;
         end
      end
   end

   // Monitor: per-cycle stall/bus checks and scoreboard pop on every done pulse
   initial begin
      exp_t e;
      int   txn = 0;
      forever begin
         @(negedge clk);
         #3;
         check("cpu_stall", cpu_stall, rst ? 1'b0 : (cpu_req & ~cpu_done));
         if (bus_req && exp_q.size() > 0) begin
            check("PrAddr", PrAddr, exp_q[0].addr);
            check("PrWD", PrWD, exp_q[0].wd);
            check("PrBE", PrBE, exp_q[0].be);
            check("IOWrite", IOWrite, exp_q[0].we);
         end
         if (cpu_done || dma_done) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: cpu_done=%b dma_done=%b with nothing outstanding",
                        cpu_done, dma_done);
            end else begin
               e = exp_q.pop_front();
               txn++;
               check("done_owner", {cpu_done, dma_done}, e.own_dma ? 2'b01 : 2'b10);
               check("rd_data", e.own_dma ? dma_rd : cpu_rd, e.rd);
               check("bus_err", bus_err, e.err);
               $display("txn %0d owner=%s we=%0d addr=%08h wd=%08h be=%h rd=%08h err=%0d",
                        txn, e.own_dma ? "DMA" : "CPU", e.we, e.addr, e.wd, e.be,
                        e.own_dma ? dma_rd : cpu_rd, bus_err);
            end
         end else begin
            check("bus_err_no_done", bus_err, 1'b0);
         end
      end
   end

   initial begin
      #1000000;
      checks++;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      finish_sim();
   end

   initial begin
      bit w;
      int idle;
      repeat (3) step();
      check("rst_bus_req", bus_req, 1'b0);
      check("rst_done", {cpu_done, dma_done, bus_err, IOWrite}, 4'b0);
      check("rst_bus_fields", {PrAddr, PrWD, PrBE}, '0);
      check("rst_rd", {cpu_rd, dma_rd}, '0);
      rst = 1'b0;
      step();

      // Single CPU read, zero-wait device
      set_cpu(1'b0, 30'h0000_0040, 32'h0, 4'hF);
      serve(0, 1'b0, 32'h1234_5678, 1'b0, w);

      // Stray ack in IDLE with nobody requesting
      step();
      stray_ack = 1'b1;
      step();
      stray_ack = 1'b0;
      repeat (3) begin
         step();
         check("stray_ack_quiet", {bus_req, cpu_done, dma_done}, 3'b0);
      end

      // DMA write with three wait states
      set_dma(1'b1, 30'h100, 32'hA5A5_A5A5, 4'b0011);
      serve(3, 1'b0, 32'h0BAD_F00D, 1'b0, w);

      // Starvation: DMA held, CPU re-requests; fifth grant goes to DMA
      rand_cpu();
      rand_dma();
      for (int i = 0; i < 5; i++) begin
         serve($urandom_range(0, 2), 1'b0, $urandom, 1'b1, w);
         if (!w) rand_cpu();
      end
      serve(0, 1'b0, $urandom, 1'b1, w);

      // Reset during CPU_BUS after starve count has saturated
      rand_cpu();
      rand_dma();
      for (int i = 0; i < 3; i++) begin
         serve(0, 1'b0, $urandom, 1'b1, w);
         rand_cpu();
      end
      dev_wait = 10;
      step();
      step();
      check("pre_reset_bus_req", bus_req, 1'b1);
      rst = 1'b1;
      step();
      check("reset_drops_bus_req", bus_req, 1'b0);
      check("reset_no_done", {cpu_done, dma_done}, 2'b00);
      check("reset_stall_forced", cpu_stall, 1'b0);
      rst = 1'b0;
      m_starve = 0;
      serve(1, 1'b0, $urandom, 1'b0, w);
      serve(0, 1'b0, $urandom, 1'b1, w);

`ifdef PR_BUS_TIMEOUT_EN
      // Never-acked read aborts; ack on the expiry cycle completes normally
      set_cpu(1'b0, 30'h3FF, 32'h0, 4'hF);
      serve(0, 1'b1, 32'h0, 1'b1, w);
      set_cpu(1'b0, 30'h3FE, 32'h0, 4'hF);
      serve(TIMEOUT_CYC - 1, 1'b0, 32'hCAFE_0001, 1'b1, w);
`endif

      // Randomised traffic
      for (int r = 0; r < 150; r++) begin
         idle = 0;
         if (!cpu_pend && $urandom_range(0, 3) != 0) rand_cpu();
         if (!dma_pend && $urandom_range(0, 2) == 0) rand_dma();
         if (!cpu_pend && !dma_pend) begin
            idle = 1 + $urandom_range(0, 1);
            repeat (idle) step();
            if ($urandom_range(0, 1) != 0) rand_cpu();
            else                           rand_dma();
         end
         serve($urandom_range(0, 4), 1'b0, $urandom, idle == 0, w);
      end
      while (cpu_pend || dma_pend) serve($urandom_range(0, 2), 1'b0, $urandom, 1'b1, w);

      repeat (4) step();
      check("scoreboard_empty", exp_q.size(), 0);
      finish_sim();
   end

endmodule
